// File: rtl/button_event.sv
// Turns a debounced button level into press/release/short/long/repeat pulses plus a held level.
// Define DOUBLE_CLICK_EN to add the dbl_click port and the post-release double-click window.
// The release and repeat outputs are named release_evt/repeat_evt because release/repeat are language keywords.
module button_event #(
  parameter logic             ACTIVE_LVL = 1'b0,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] LONG_MS    = 16'd1000,
  parameter logic [CNT_W-1:0] REPEAT_MS  = 16'd200,
  parameter logic [CNT_W-1:0] DBL_MS     = 16'd300
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  input  logic ms_tck,
  output logic press,
  output logic release_evt,
  output logic short_press,
  output logic long_press,
  output logic repeat_evt,
  output logic held
`ifdef DOUBLE_CLICK_EN
  ,
  output logic dbl_click
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
`ifdef DOUBLE_CLICK_EN
    ,
    WAIT2
`endif
  } state_t;

  state_t           state_reg;
  logic             sig_q_reg;
  logic [CNT_W-1:0] ms_cnt_reg;
  logic [CNT_W-1:0] rpt_cnt_reg;
  logic [CNT_W-1:0] ms_cnt_next;
  logic [CNT_W-1:0] rpt_cnt_next;
  logic             rise;
  logic             fall;

  assign rise         = (sig_in == ACTIVE_LVL) && (sig_q_reg != ACTIVE_LVL);
  assign fall         = (sig_in != ACTIVE_LVL) && (sig_q_reg == ACTIVE_LVL);
  assign ms_cnt_next  = ms_cnt_reg + CNT_W'(1);
  assign rpt_cnt_next = rpt_cnt_reg + CNT_W'(1);

`ifdef DOUBLE_CLICK_EN
  logic dbl_flag_reg;
`else
  logic unused_dbl_ms;
  assign unused_dbl_ms = ^DBL_MS;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      sig_q_reg   <= ~ACTIVE_LVL;
      ms_cnt_reg  <= '0;
      rpt_cnt_reg <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
      held        <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      dbl_flag_reg <= 1'b0;
      dbl_click    <= 1'b0;
`endif
    end else begin
      sig_q_reg   <= sig_in;
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      dbl_click   <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
`ifdef DOUBLE_CLICK_EN
          dbl_flag_reg <= 1'b0;
`endif
          if (rise) begin
            press      <= 1'b1;
            held       <= 1'b1;
            ms_cnt_reg <= '0;
            state_reg  <= PRESSED;
          end
        end
        PRESSED: begin
          // A fall on the same edge as the threshold tick is still a short press.
          if (fall) begin
            release_evt <= 1'b1;
            held        <= 1'b0;
`ifdef DOUBLE_CLICK_EN
            if (dbl_flag_reg) begin
              state_reg <= IDLE;
            end else begin
              short_press <= 1'b1;
              ms_cnt_reg  <= '0;
              state_reg   <= WAIT2;
            end
`else
            short_press <= 1'b1;
            state_reg   <= IDLE;
`endif
          end else if (ms_tck) begin
            ms_cnt_reg <= ms_cnt_next;
            if (ms_cnt_next == LONG_MS) begin
              long_press  <= 1'b1;
              rpt_cnt_reg <= '0;
              state_reg   <= LONG;
            end
          end
        end
        LONG: begin
          if (fall) begin
            release_evt <= 1'b1;
            held        <= 1'b0;
            state_reg   <= IDLE;
          end else if (ms_tck) begin
            if (rpt_cnt_next == REPEAT_MS) begin
              repeat_evt  <= 1'b1;
              rpt_cnt_reg <= '0;
            end else begin
              rpt_cnt_reg <= rpt_cnt_next;
            end
          end
        end
`ifdef DOUBLE_CLICK_EN
        WAIT2: begin
          // A second press on the closing tick still counts as a double click.
          if (rise) begin
            press        <= 1'b1;
            dbl_click    <= 1'b1;
            dbl_flag_reg <= 1'b1;
            held         <= 1'b1;
            ms_cnt_reg   <= '0;
            state_reg    <= PRESSED;
          end else if (ms_tck) begin
            ms_cnt_reg <= ms_cnt_next;
            if (ms_cnt_next == DBL_MS) begin
              state_reg <= IDLE;
            end
          end
        end
`endif
        default: begin
          held      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: a tick-counting event model checked every cycle, plus literal spot checks.
// Exercises the DOUBLE_CLICK_EN window only when that macro is defined.
`timescale 1ns/1ps
module tb_button_event;

  localparam int LONG = 5;
  localparam int RPT  = 2;
  localparam int DBL  = 4;
`ifdef DOUBLE_CLICK_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  // Output vector order: press, release, short, long, repeat, held, dbl_click
  localparam logic [6:0] M_PRESS = 7'b1000000;
  localparam logic [6:0] M_REL   = 7'b0100000;
  localparam logic [6:0] M_SHORT = 7'b0010000;
  localparam logic [6:0] M_LONG  = 7'b0001000;
  localparam logic [6:0] M_RPT   = 7'b0000100;
  localparam logic [6:0] M_HELD  = 7'b0000010;
  localparam logic [6:0] M_DBL   = 7'b0000001;
  localparam logic [6:0] M_ALL   = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b1;
  logic ms_tck = 1'b0;
  logic press, release_evt, short_press, long_press, repeat_evt, held, dbl_click;

  button_event #(
    .ACTIVE_LVL(1'b0),
    .CNT_W(16),
    .LONG_MS(16'd5),
    .REPEAT_MS(16'd2),
    .DBL_MS(16'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sig_in(sig_in),
    .ms_tck(ms_tck),
    .press(press),
    .release_evt(release_evt),
    .short_press(short_press),
    .long_press(long_press),
    .repeat_evt(repeat_evt),
    .held(held)
`ifdef DOUBLE_CLICK_EN
    ,
    .dbl_click(dbl_click)
`endif
  );

`ifndef DOUBLE_CLICK_EN
  assign dbl_click = 1'b0;
`endif

  always #5 clk = ~clk;

  // Model: counts ticks of the current hold and of the post-release window.
  typedef struct packed {
    bit         prev_act;
    bit         pushed;
    bit         dbl_press;
    bit         win_open;
    int         hold_ticks;
    int         win_ticks;
    logic [6:0] out;
  } mstate_t;

  function automatic mstate_t model_step(input mstate_t s, input logic sig, input logic tck);
    mstate_t n;
    bit act, rise, fall;
    n    = s;
    act  = (sig == 1'b0);
    rise = act && !s.prev_act;
    fall = !act && s.prev_act;
    n.out = '0;
    n.prev_act = act;
    if (rise) begin
      n.out[6]     = 1'b1;
      n.out[0]     = DC_EN && s.win_open;
      n.dbl_press  = DC_EN && s.win_open;
      n.pushed     = 1'b1;
      n.hold_ticks = 0;
      n.win_open   = 1'b0;
    end else if (fall) begin
      n.out[5]    = 1'b1;
      n.out[4]    = (s.hold_ticks < LONG) && !s.dbl_press;
      n.win_open  = DC_EN && (s.hold_ticks < LONG) && !s.dbl_press;
      n.win_ticks = 0;
      n.pushed    = 1'b0;
    end else if (tck) begin
      if (s.pushed) begin
        n.hold_ticks = s.hold_ticks + 1;
        n.out[3] = (n.hold_ticks == LONG);
        n.out[2] = (n.hold_ticks > LONG) && (((n.hold_ticks - LONG) % RPT) == 0);
      end else if (s.win_open) begin
        n.win_ticks = s.win_ticks + 1;
        if (n.win_ticks >= DBL) n.win_open = 1'b0;
      end
    end
    n.out[1] = n.pushed;
    return n;
  endfunction

  mstate_t m = '0;
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= model_step(m, sig_in, ms_tck);
  end

  // Literal spot-check requests, handed from stimulus to the compare process.
  int         lit_seq = 0;
  string      lit_name = "";
  logic [6:0] lit_mask = '0;
  logic [6:0] lit_exp = '0;
  bit         armed = 1'b0;

  int         total = 0;
  int         bad = 0;
  int         lit_done = 0;
  logic [6:0] got;

  always @(negedge clk) begin
    if (armed) begin
      got = {press, release_evt, short_press, long_press, repeat_evt, held, dbl_click};
      total++;
      if (got !== m.out) begin
        bad++;
        $display("FAIL cycle_check t=%0t dut=%b required=%b", $time, got, m.out);
      end
      if (lit_seq != lit_done) begin
        lit_done = lit_seq;
        total++;
        if ((got & lit_mask) !== (lit_exp & lit_mask)) begin
          bad++;
          $display("FAIL %s t=%0t dut=%b required=%b mask=%b", lit_name, $time, got, lit_exp, lit_mask);
        end
        total++;
        if ((m.out & lit_mask) !== (lit_exp & lit_mask)) begin
          bad++;
          $display("FAIL %s_model t=%0t model=%b required=%b mask=%b", lit_name, $time, m.out, lit_exp, lit_mask);
        end
      end
    end
  end

  int phase = 0;

  task automatic step();
    @(posedge clk);
    #2;
    phase  = (phase + 1) % 3;
    ms_tck = (phase == 0);
  endtask

  // Returns with the n-th upcoming tick presented but not yet sampled.
  task automatic ticks(input int n);
    int c;
    c = ms_tck ? 1 : 0;
    while (c < n) begin
      step();
      if (ms_tck) c++;
    end
  endtask

  task automatic expect_lit(input string nm, input logic [6:0] mask, input logic [6:0] exp_v);
    lit_name = nm;
    lit_mask = mask;
    lit_exp  = exp_v;
    lit_seq++;
  endtask

  initial begin
    #1;
    rst   = 1'b0;
    armed = 1'b1;

    // Reset held with a toggling input, then release while idle.
    for (int i = 0; i < 6; i++) begin
      step();
      sig_in = ~sig_in;
    end
    expect_lit("reset_quiet", M_ALL, 7'b0);
    step();
    sig_in = 1'b1;
    step();
    rst = 1'b1;
    repeat (5) step();
    expect_lit("post_reset_idle", M_ALL, 7'b0);
    step();

    // Short press: 3 ticks.
    sig_in = 1'b0;
    step();
    expect_lit("t2_press", M_PRESS | M_HELD | M_LONG, M_PRESS | M_HELD);
    step();
    expect_lit("t2_press_once", M_PRESS | M_HELD, M_HELD);
    ticks(3);
    step();
    sig_in = 1'b1;
    step();
    expect_lit("t2_release", M_PRESS | M_REL | M_SHORT | M_LONG | M_HELD, M_REL | M_SHORT);
    step();
    expect_lit("t2_after", M_REL | M_SHORT, 7'b0);
    step();

    // Long press: 10 ticks, repeats on 7 and 9.
    repeat (8) step();
    sig_in = 1'b0;
    step();
    expect_lit("t3_press", M_PRESS, M_PRESS);
    ticks(5);
    step();
    expect_lit("t3_long", M_LONG | M_RPT | M_HELD, M_LONG | M_HELD);
    ticks(2);
    step();
    expect_lit("t3_rpt7", M_RPT | M_LONG, M_RPT);
    ticks(2);
    step();
    expect_lit("t3_rpt9", M_RPT | M_LONG, M_RPT);
    ticks(1);
    step();
    expect_lit("t3_tick10_quiet", M_RPT | M_LONG | M_HELD, M_HELD);
    sig_in = 1'b1;
    step();
    expect_lit("t3_release", M_REL | M_SHORT | M_HELD, M_REL);
    step();

    // Release on the same edge as tick 5.
    repeat (4) step();
    sig_in = 1'b0;
    step();
    ticks(5);
    sig_in = 1'b1;
    step();
    expect_lit("t4_fall_wins", M_REL | M_SHORT | M_LONG | M_HELD, M_REL | M_SHORT);
    step();
    expect_lit("t4_no_late_long", M_LONG | M_HELD, 7'b0);
    step();

    // Asynchronous reset mid-LONG, then restart with the button still pushed.
    repeat (4) step();
    sig_in = 1'b0;
    step();
    ticks(6);
    step();
    #1;
    rst = 1'b0;
    expect_lit("t5_async_reset", M_ALL, 7'b0);
    step();
    step();
    rst = 1'b1;
    step();
    expect_lit("t5_press", M_PRESS | M_HELD, M_PRESS | M_HELD);
    ticks(5);
    step();
    expect_lit("t5_long", M_LONG | M_HELD, M_LONG | M_HELD);
    sig_in = 1'b1;
    step();
    expect_lit("t5_release", M_REL | M_SHORT, M_REL);
    step();

`ifdef DOUBLE_CLICK_EN
    // Double click: 1-tick presses two ticks apart, then five ticks apart.
    repeat (4) step();
    sig_in = 1'b0;
    step();
    ticks(1);
    step();
    sig_in = 1'b1;
    step();
    expect_lit("t6_first_short", M_REL | M_SHORT, M_REL | M_SHORT);
    ticks(2);
    step();
    sig_in = 1'b0;
    step();
    expect_lit("t6_dbl", M_PRESS | M_DBL, M_PRESS | M_DBL);
    ticks(1);
    step();
    sig_in = 1'b1;
    step();
    expect_lit("t6_no_short", M_REL | M_SHORT, M_REL);
    ticks(5);
    step();
    sig_in = 1'b0;
    step();
    ticks(1);
    step();
    sig_in = 1'b1;
    step();
    ticks(5);
    step();
    sig_in = 1'b0;
    step();
    expect_lit("t6_gap5_no_dbl", M_PRESS | M_DBL, M_PRESS);
    ticks(1);
    step();
    sig_in = 1'b1;
    step();
    expect_lit("t6_gap5_short", M_REL | M_SHORT, M_REL | M_SHORT);
    step();
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
